// File: rtl/mat_cache_ctrl.sv
// rtl/mat_cache_ctrl.sv - MatCache command sequencer: row loads, row/diagonal reads.
// Cache opcode types live in mat_cache_pkg so the cache and controller share one encoding.

package mat_cache_pkg;

  typedef enum logic [1:0] {
    MAT_CACHE_WRITE_NOP = 2'd0,
    MAT_CACHE_WRITE_ROW = 2'd1
  } MatCacheWriteOp_t;

  typedef enum logic [1:0] {
    MAT_CACHE_READ_NOP  = 2'd0,
    MAT_CACHE_READ_ROW  = 2'd1,
    MAT_CACHE_READ_DIAG = 2'd2
  } MatCacheReadOp_t;

endpackage

module mat_cache_ctrl
  import mat_cache_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int CACHE_SIZE = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [1:0]                    cmd_op,
  input  logic [$clog2(CACHE_SIZE)-1:0] cmd_addr,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output MatCacheWriteOp_t              write_op,
  output logic [$clog2(CACHE_SIZE)-1:0] write_addr1,
  output logic [$clog2(WIDTH)-1:0]      write_param,
  output MatCacheReadOp_t               read_op,
  output logic [$clog2(CACHE_SIZE)-1:0] read_addr1,
  output logic [$clog2(CACHE_SIZE)-1:0] read_addr2,
  output logic [$clog2(WIDTH)-1:0]      read_param,
  output logic                          busy,
  output logic                          err
);

  localparam int IW = $clog2(WIDTH);
  localparam int AW = $clog2(CACHE_SIZE);

  localparam logic [1:0] OP_LOAD  = 2'd0;
  localparam logic [1:0] OP_ROWS  = 2'd1;
  localparam logic [1:0] OP_DIAGS = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_READ = 2'd2
  } state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [AW-1:0] slot;
  logic          diag_mode;
  logic          idx_last;

  assign idx_last = (idx == IW'(WIDTH - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      slot      <= '0;
      diag_mode <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            case (cmd_op)
              OP_LOAD: begin
                slot  <= cmd_addr;
                idx   <= '0;
                state <= S_LOAD;
              end
              OP_ROWS, OP_DIAGS: begin
                slot      <= cmd_addr;
                diag_mode <= (cmd_op == OP_DIAGS);
                idx       <= '0;
                state     <= S_READ;
              end
              default: err <= 1'b1;
            endcase
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            if (idx_last) begin
              idx   <= '0;
              state <= S_IDLE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        S_READ: begin
          // out_valid is constantly high in READ, so out_ready alone is the handshake
          if (out_ready) begin
            if (idx_last) begin
              idx   <= '0;
              state <= S_IDLE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: begin
          idx   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Cache ops are decoded from state so a reset clears them in the same cycle
  always_comb begin
    write_op    = MAT_CACHE_WRITE_NOP;
    write_addr1 = '0;
    write_param = '0;
    read_op     = MAT_CACHE_READ_NOP;
    read_addr1  = '0;
    read_addr2  = '0;
    read_param  = '0;
    if (state == S_LOAD && in_valid) begin
      write_op    = MAT_CACHE_WRITE_ROW;
      write_addr1 = slot;
      write_param = idx;
    end
    if (state == S_READ) begin
      read_op    = diag_mode ? MAT_CACHE_READ_DIAG : MAT_CACHE_READ_ROW;
      read_addr1 = slot;
      read_addr2 = slot;
      read_param = idx;
    end
  end

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign in_ready  = (state == S_LOAD);
  assign out_valid = (state == S_READ);
  assign out_last  = (state == S_READ) && idx_last;

endmodule

// File: tb/tb_mat_cache_ctrl.sv
// tb/tb_mat_cache_ctrl.sv - checks mat_cache_ctrl against a command-level model and a bench-side cache.

module tb_mat_cache_ctrl;
  import mat_cache_pkg::*;

  localparam int W  = 4;
  localparam int CS = 4;

  logic             clock;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [1:0]       cmd_addr;
  logic             in_valid;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  MatCacheWriteOp_t write_op;
  logic [1:0]       write_addr1;
  logic [1:0]       write_param;
  MatCacheReadOp_t  read_op;
  logic [1:0]       read_addr1;
  logic [1:0]       read_addr2;
  logic [1:0]       read_param;
  logic             busy;
  logic             err;

  mat_cache_ctrl #(.WIDTH(W), .CACHE_SIZE(CS)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .write_op(write_op), .write_addr1(write_addr1), .write_param(write_param),
    .read_op(read_op), .read_addr1(read_addr1), .read_addr2(read_addr2), .read_param(read_param),
    .busy(busy), .err(err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // cmem is the cache as driven by the DUT; ref_mem is what the model says it must hold
  int cmem    [CS][W][W];
  int ref_mem [CS][W][W];
  int din     [W];

  // model: current command kind (0 idle, 1 load, 2 rows, 3 diags), slot, beat number
  int m_kind, m_slot, m_beat, m_err;
  int n_writes, n_beats;

  int tbl [3][W][W] = '{
    '{'{4,6,1,6}, '{1,2,3,4}, '{3,3,3,3}, '{9,7,5,3}},
    '{'{1,0,0,2}, '{0,1,2,0}, '{5,5,0,0}, '{0,0,6,6}},
    '{'{8,8,8,8}, '{5,4,3,2}, '{7,7,7,7}, '{1,1,1,1}}
  };

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic int pk(input int a, input int b, input int c, input int d);
    return (d << 24) | (c << 16) | (b << 8) | a;
  endfunction

  // Cache read: row p, or diagonal p where element i is row i, column (p - i) mod W
  function automatic int rd(input bit use_ref, input int op, input int a, input int p);
    int w, r, c, v;
    w = 0;
    for (int i = 0; i < W; i++) begin
      r = (op == 2) ? i : p;
      c = (op == 2) ? (p - i + W) % W : i;
      v = use_ref ? ref_mem[a][r][c] : cmem[a][r][c];
      w = w | ((v & 255) << (8 * i));
    end
    return w;
  endfunction

  initial begin
    for (int s = 0; s < CS; s++)
      for (int r = 0; r < W; r++)
        for (int c = 0; c < W; c++) begin
          cmem[s][r][c]    = 0;
          ref_mem[s][r][c] = 0;
        end
    m_kind = 0; m_slot = 0; m_beat = 0; m_err = 0;
    n_writes = 0; n_beats = 0;
  end

  always @(negedge clock) begin
    int nerr;
    bit rd_act, wr_act;
    if (reset) begin
      m_kind = 0;
      m_beat = 0;
      m_err  = 0;
    end
    wr_act = (m_kind == 1) && in_valid;
    rd_act = (m_kind >= 2);
    chk("cmd_ready", int'(cmd_ready), (m_kind == 0) ? 1 : 0);
    chk("busy",      int'(busy),      (m_kind != 0) ? 1 : 0);
    chk("err",       int'(err),       m_err);
    chk("in_ready",  int'(in_ready),  (m_kind == 1) ? 1 : 0);
    chk("out_valid", int'(out_valid), rd_act ? 1 : 0);
    chk("out_last",  int'(out_last),  (rd_act && m_beat == W - 1) ? 1 : 0);
    chk("write_op",  int'(write_op),  wr_act ? 1 : 0);
    chk("read_op",   int'(read_op),   rd_act ? m_kind - 1 : 0);
    if (wr_act || reset) begin
      chk("write_addr1", int'(write_addr1), reset ? 0 : m_slot);
      chk("write_param", int'(write_param), reset ? 0 : m_beat);
    end
    if (rd_act || reset) begin
      chk("read_addr1", int'(read_addr1), reset ? 0 : m_slot);
      chk("read_addr2", int'(read_addr2), reset ? 0 : m_slot);
      chk("read_param", int'(read_param), reset ? 0 : m_beat);
    end
    if (rd_act)
      chk("data_out", rd(1'b0, int'(read_op), int'(read_addr1), int'(read_param)),
          rd(1'b1, m_kind - 1, m_slot, m_beat));

    if (write_op == MAT_CACHE_WRITE_ROW) begin
      n_writes++;
      for (int c = 0; c < W; c++) cmem[write_addr1][write_param][c] = din[c];
    end
    if (out_valid && out_ready) n_beats++;

    // advance the model across the coming posedge
    if (!reset) begin
      nerr = 0;
      if (m_kind == 0) begin
        if (cmd_valid) begin
          if (cmd_op == 2'd3) nerr = 1;
          else begin
            m_kind = int'(cmd_op) + 1;
            m_slot = int'(cmd_addr);
            m_beat = 0;
          end
        end
      end else if ((m_kind == 1 && in_valid) || (m_kind >= 2 && out_ready)) begin
        if (m_kind == 1)
          for (int c = 0; c < W; c++) ref_mem[m_slot][m_beat][c] = din[c];
        if (m_beat == W - 1) begin
          m_kind = 0;
          m_beat = 0;
        end else begin
          m_beat++;
        end
      end
      m_err = nerr;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_cmd(input int op, input int addr);
    cmd_valid = 1'b1;
    cmd_op    = 2'(op);
    cmd_addr  = 2'(addr);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic load_rows(input int slot, input int sel, input bit gap, input int nrows);
    do_cmd(0, slot);
    for (int r = 0; r < nrows; r++) begin
      if (gap) begin
        in_valid = 1'b0;
        @(negedge clock);
        chk("gap_no_write", int'(write_op), 0);
        step();
      end
      in_valid = 1'b1;
      for (int c = 0; c < W; c++) din[c] = tbl[sel][r][c];
      @(negedge clock);
      chk("load_param", int'(write_param), r);
      chk("load_op", int'(write_op), 1);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic read_check(input int op, input int slot, input int e0, input int e1,
                            input int e2, input int e3);
    int e [W];
    e = '{e0, e1, e2, e3};
    out_ready = 1'b1;
    do_cmd(op, slot);
    for (int b = 0; b < W; b++) begin
      @(negedge clock);
      chk("beat_data", rd(1'b0, int'(read_op), int'(read_addr1), int'(read_param)), e[b]);
      chk("beat_last", int'(out_last), (b == W - 1) ? 1 : 0);
      step();
    end
    @(negedge clock);
    chk("read_done_idle", int'(cmd_ready), 1);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = 2'd0;
    in_valid = 1'b0; out_ready = 1'b0;
    for (int c = 0; c < W; c++) din[c] = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_write_op", int'(write_op), 0);
    chk("rst_read_op", int'(read_op), 0);
    step();
    reset = 1'b0;
    step();

    load_rows(1, 0, 1'b0, W);
    @(negedge clock);
    chk("load_done_ready", int'(cmd_ready), 1);
    step();

    read_check(2, 1, pk(4,4,3,7), pk(6,1,3,5), pk(1,2,3,3), pk(6,3,3,9));

    // rows read with a 3-cycle stall at idx 2
    n_beats = 0;
    out_ready = 1'b1;
    do_cmd(1, 1);
    step();
    step();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("stall_param", int'(read_param), 2);
      chk("stall_row", rd(1'b0, int'(read_op), int'(read_addr1), int'(read_param)), pk(3,3,3,3));
      step();
    end
    out_ready = 1'b1;
    step();
    @(negedge clock);
    chk("stall_last", int'(out_last), 1);
    step();
    chk("stall_beats", n_beats, 4);

    n_writes = 0;
    load_rows(2, 1, 1'b1, W);
    step();
    chk("gap_writes", n_writes, 4);
    read_check(1, 2, pk(1,0,0,2), pk(0,1,2,0), pk(5,5,0,0), pk(0,0,6,6));

    do_cmd(3, 0);
    @(negedge clock);
    chk("rsv_err", int'(err), 1);
    chk("rsv_busy", int'(busy), 0);
    chk("rsv_wop", int'(write_op), 0);
    chk("rsv_rop", int'(read_op), 0);
    step();
    @(negedge clock);
    chk("rsv_err_clear", int'(err), 0);
    step();

    // abandon a load at idx 2 with reset
    load_rows(1, 2, 1'b0, 2);
    in_valid = 1'b1;
    for (int c = 0; c < W; c++) din[c] = tbl[2][2][c];
    reset = 1'b1;
    @(negedge clock);
    chk("abort_busy", int'(busy), 0);
    chk("abort_ready", int'(cmd_ready), 1);
    chk("abort_wop", int'(write_op), 0);
    chk("abort_waddr", int'(write_addr1), 0);
    chk("abort_wparam", int'(write_param), 0);
    step();
    reset = 1'b0;
    in_valid = 1'b0;
    step();
    read_check(1, 1, pk(8,8,8,8), pk(5,4,3,2), pk(3,3,3,3), pk(9,7,5,3));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mat_cache_ctrl.md
MAT_CACHE_CTRL -- requirements
Module: mat_cache_ctrl

Interface
REQ-001 Parameter: WIDTH, default 4, matrix dimension; rows per load and vectors per read.
REQ-002 Parameter: CACHE_SIZE, default 4, number of matrix slots in the attached MatCache.
REQ-003 Port: clock  input  1  single clock; all state updates on posedge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: cmd_valid  input  1  command offered.
REQ-006 Port: cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at posedge.
REQ-007 Port: cmd_op  input  2  0=LOAD, 1=READ_ROWS, 2=READ_DIAGS, 3=reserved.
REQ-008 Port: cmd_addr  input  $clog2(CACHE_SIZE)  target cache slot.
REQ-009 Port: in_valid  input  1  load-row data present on the cache data_in bus.
REQ-010 Port: in_ready  output  1  controller will write the present row this cycle.
REQ-011 Port: out_valid  output  1  cache data_out holds a valid row/diagonal this cycle.
REQ-012 Port: out_ready  input  1  consumer takes data_out at posedge.
REQ-013 Port: out_last  output  1  current out_valid beat is index WIDTH-1.
REQ-014 Port: write_op  output  MatCacheWriteOp_t  cache write opcode.
REQ-015 Port: write_addr1, write_param  output  $clog2(CACHE_SIZE), $clog2(WIDTH)  slot, row index.
REQ-016 Port: read_op  output  MatCacheReadOp_t  cache read opcode.
REQ-017 Port: read_addr1, read_addr2, read_param  output  $clog2(CACHE_SIZE), $clog2(CACHE_SIZE), $clog2(WIDTH)  slots, index.
REQ-018 Port: busy  output  1  high in any state other than IDLE.
REQ-019 Port: err  output  1  one-cycle pulse on acceptance of a reserved cmd_op.

Function
REQ-020 States: IDLE, LOAD, READ; index counter idx (0..WIDTH-1); latched slot and mode registers.
REQ-021 cmd_ready = 1 only in IDLE; a command is accepted on the posedge where cmd_valid && cmd_ready.
REQ-022 Accepted LOAD: latch cmd_addr, idx<=0, go to LOAD next cycle.
REQ-023 Accepted READ_ROWS/READ_DIAGS: latch cmd_addr and mode, idx<=0, go to READ next cycle.
REQ-024 Accepted reserved op: err=1 the following cycle only; remain IDLE; no cache op issued.
REQ-025 LOAD: in_ready=1; write_op=MAT_CACHE_WRITE_ROW, write_addr1=slot, write_param=idx, combinationally, only when in_valid=1; otherwise write_op=MAT_CACHE_WRITE_NOP.
REQ-026 LOAD: idx increments on each in_valid handshake; handshake at idx=WIDTH-1 returns to IDLE, idx<=0.
REQ-027 READ: read_op=MAT_CACHE_READ_ROW (READ_ROWS) or MAT_CACHE_READ_DIAG (READ_DIAGS); read_addr1=read_addr2=slot; read_param=idx; out_valid=1 every cycle in READ.
REQ-028 Cache read is combinational, so out_valid and data_out are coincident; zero added latency.
REQ-029 READ: idx advances only on out_valid && out_ready; out_last=1 when idx=WIDTH-1; that handshake returns to IDLE.
REQ-030 out_ready=0 holds idx, read_op and read_param stable (no skipped or repeated index).
REQ-031 Outside LOAD, write_op=MAT_CACHE_WRITE_NOP; outside READ, read_op=MAT_CACHE_READ_NOP; in_ready=out_valid=out_last=0.
REQ-032 A new command accepted in IDLE starts exactly 1 cycle after acceptance; back-to-back commands have one IDLE cycle between them.
REQ-033 Throughput: a full LOAD or READ with constant valid/ready takes WIDTH cycles.

Reset
REQ-034 Reset asserted: state=IDLE, idx=0, slot=0, err=0, busy=0, cmd_ready=1, write_op=WRITE_NOP, read_op=READ_NOP, all addr/param outputs 0, immediately and asynchronously.
REQ-035 Reset mid-LOAD or mid-READ abandons the command; rows already written remain in the cache (the cache has no reset); no completion signalled.

Verification
REQ-036 LOAD slot 1, in_valid constant, rows (4,6,1,6),(1,2,3,4),(3,3,3,3),(9,7,5,3) -> WRITE_ROW with params 0..3 over 4 cycles, then IDLE, cmd_ready=1.
REQ-037 READ_DIAGS slot 1 after REQ-036, out_ready=1 -> beats (4,4,3,7),(6,1,3,5),(1,2,3,3),(6,3,3,9); out_last only on beat 4.
REQ-038 READ_ROWS slot 1 with out_ready low for 3 cycles at idx=2 -> read_param stays 2, row (3,3,3,3) held; 4 beats total.
REQ-039 LOAD with in_valid gaps (1 of every 2 cycles) -> exactly 4 WRITE_ROW cycles, params 0..3, no writes during gaps.
REQ-040 cmd_op=3 in IDLE -> err pulse one cycle, busy stays 0, no cache op.
REQ-041 Reset asserted at idx=2 of a LOAD -> all outputs at REQ-034 values same cycle; subsequent READ_ROWS returns rows 0,1 new, rows 2,3 previous contents.
